// File: rtl/tws_pkg.sv
// Shared TWS bus definitions: field widths, command encodings and the master
// FSM state set, used by both the master and the slave.
package tws_pkg;

  localparam int unsigned TWS_ADDR_W = 8;
  localparam int unsigned TWS_DATA_W = 16;

  localparam logic TWS_CMD_WR = 1'b1;
  localparam logic TWS_CMD_RD = 1'b0;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_CMD,
    ST_ADDR,
    ST_WDATA,
    ST_TURN,
    ST_RDATA,
    ST_STOP,
    ST_TURNBACK,
    ST_RESP,
    ST_GAP
  } tws_state_e;

  // States in which the master leaves SDA to the pull-up / slave.
  function automatic logic tws_released(input tws_state_e s);
    return (s == ST_TURN) || (s == ST_RDATA) || (s == ST_STOP) || (s == ST_TURNBACK);
  endfunction

endpackage

// File: rtl/tws_master_if.sv
// Host-side command/response port of the TWS master.
interface tws_master_if;

  logic                             cmd_valid;
  logic                             cmd_ready;
  logic                             cmd_rw;
  logic [tws_pkg::TWS_ADDR_W-1:0]   cmd_addr;
  logic [tws_pkg::TWS_DATA_W-1:0]   cmd_wdata;
  logic                             rsp_valid;
  logic [tws_pkg::TWS_DATA_W-1:0]   rsp_rdata;
  logic                             rsp_err;
  logic                             busy;

  modport master (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

endinterface

// File: rtl/tws_shift16.sv
// 16-bit LSB-first shift register: parallel load, shift right with serial
// input at the MSB; bit 0 is the serial output.
module tws_shift16
  import tws_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [TWS_DATA_W-1:0] load_val,
  input  logic                  shift,
  input  logic                  sin,
  output logic [TWS_DATA_W-1:0] q,
  output logic                  sout
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {sin, q[TWS_DATA_W-1:1]};
    end
  end

  assign sout = q[0];

endmodule

// File: rtl/tws_master.sv
// TWS single-wire bus master: serialises host commands onto SDA and, for
// reads, turns the line around and deserialises the slave's 16-bit reply.
module tws_master
  import tws_pkg::*;
#(
  parameter int unsigned GAP_CYC = 2,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst,
  tws_master_if.master     host,
  inout  wire              SDA
);

  localparam logic [4:0] ADDR_LAST = 5'(TWS_ADDR_W - 1);
  localparam logic [4:0] DATA_LAST = 5'(TWS_DATA_W - 1);
  localparam logic [4:0] TO_LAST   = 5'(TIMEOUT - 1);
  // The response cycle is the first of the GAP_CYC drive-high cycles.
  localparam logic [4:0] GAP_LAST  = (GAP_CYC >= 2) ? 5'(GAP_CYC - 2) : '0;

  tws_state_e state, next;

  logic [4:0]            cnt, cnt_nxt;
  logic                  rw_q;
  logic [TWS_ADDR_W-1:0] addr_sh;
  logic                  stop_q;
  logic [TWS_DATA_W-1:0] rsp_rdata_q;
  logic                  rsp_err_q;

  logic                  accept;
  logic                  addr_shift;
  logic                  sh_shift;
  logic                  oe;
  logic                  dout;
  logic [TWS_DATA_W-1:0] sh_q;
  logic                  sh_sout;

  tws_shift16 u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (host.cmd_wdata),
    .shift    (sh_shift),
    .sin      (SDA),
    .q        (sh_q),
    .sout     (sh_sout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next       = state;
    accept     = 1'b0;
    addr_shift = 1'b0;
    sh_shift   = 1'b0;
    dout       = 1'b1;
    oe         = !tws_released(state);
    cnt_nxt    = '0;

    unique case (state)
      ST_IDLE: begin
        if (host.cmd_valid) begin
          accept = 1'b1;
          next   = ST_START;
        end
      end
      ST_START: begin
        dout = 1'b0;
        next = ST_CMD;
      end
      ST_CMD: begin
        dout = rw_q;
        next = ST_ADDR;
      end
      ST_ADDR: begin
        dout       = addr_sh[0];
        addr_shift = 1'b1;
        if (cnt == ADDR_LAST) begin
          next = (rw_q == TWS_CMD_WR) ? ST_WDATA : ST_TURN;
        end
      end
      ST_WDATA: begin
        dout     = sh_sout;
        sh_shift = 1'b1;
        if (cnt == DATA_LAST) begin
          next = ST_RESP;
        end
      end
      ST_TURN: begin
        if (SDA == 1'b0) begin
          next = ST_RDATA;
        end else if (cnt == TO_LAST) begin
          next = ST_RESP;
        end
      end
      ST_RDATA: begin
        sh_shift = 1'b1;
        if (cnt == DATA_LAST) begin
          next = ST_STOP;
        end
      end
      ST_STOP:     next = ST_TURNBACK;
      ST_TURNBACK: next = ST_RESP;
      ST_RESP:     next = (GAP_CYC >= 2) ? ST_GAP : ST_IDLE;
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          next = ST_IDLE;
        end
      end
      default: next = ST_IDLE;
    endcase

    if ((next == state) &&
        (state inside {ST_ADDR, ST_WDATA, ST_TURN, ST_RDATA, ST_GAP})) begin
      cnt_nxt = cnt + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      rw_q        <= 1'b0;
      addr_sh     <= '0;
      stop_q      <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      cnt <= cnt_nxt;

      if (accept) begin
        rw_q    <= host.cmd_rw;
        addr_sh <= host.cmd_addr;
      end else if (addr_shift) begin
        addr_sh <= {1'b0, addr_sh[TWS_ADDR_W-1:1]};
      end

      if (state == ST_STOP) begin
        stop_q <= SDA;
      end

      // Response fields are loaded on entry to RESP and held until the next one.
      if ((state != ST_RESP) && (next == ST_RESP)) begin
        if (state == ST_WDATA) begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b0;
        end else if (state == ST_TURN) begin
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b1;
        end else begin
          rsp_rdata_q <= sh_q;
          rsp_err_q   <= (stop_q != 1'b1);
        end
      end
    end
  end

  assign SDA = oe ? dout : 1'bz;

  assign host.cmd_ready = (state == ST_IDLE);
  assign host.busy      = (state != ST_IDLE);
  assign host.rsp_valid = (state == ST_RESP);
  assign host.rsp_rdata = rsp_rdata_q;
  assign host.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_tws_master.sv
// Directed bench for tws_master: a behavioural TWS slave with a 256x16
// register file on a pulled-up SDA line, table-driven commands plus corner sequences.
module tb_tws_master;

  localparam int unsigned GAP = 2;
  localparam int unsigned TO  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  tri1  SDA;

  tws_master_if bus ();

  tws_master #(.GAP_CYC(GAP), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst  (rst),
    .host (bus),
    .SDA  (SDA)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model: samples and drives on the falling edge, mid-cycle.
  logic        s_oe = 1'b0;
  logic        s_dout = 1'b1;
  logic        present = 1'b1;
  logic        bad_stop = 1'b0;
  logic [15:0] mem [256];
  int          sc = -1;
  int          cyc;
  logic        s_rw = 1'b0;
  logic [7:0]  s_addr = '0;
  logic [15:0] s_data = '0;
  logic [15:0] rd_word;
  int          wr_pulses = 0;

  assign SDA     = s_oe ? s_dout : 1'bz;
  assign cyc     = sc + 1;
  assign rd_word = mem[s_addr];

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      sc     <= -1;
      s_oe   <= 1'b0;
      s_dout <= 1'b1;
    end else if (sc < 0) begin
      if (present && SDA === 1'b0) sc <= 0;
    end else begin
      sc <= cyc;
      if (cyc == 1) begin
        s_rw <= SDA;
      end else if (cyc <= 9) begin
        s_addr[3'(cyc - 2)] <= SDA;
      end else if (s_rw) begin
        s_data[4'(cyc - 10)] <= SDA;
        if (cyc == 25) begin
          mem[s_addr] <= {SDA, s_data[14:0]};
          wr_pulses   <= wr_pulses + 1;
          sc          <= -1;
        end
      end else if (cyc == 12) begin
        s_oe   <= 1'b1;
        s_dout <= 1'b1;
      end else if (cyc == 13) begin
        s_dout <= 1'b0;
      end else if (cyc <= 29) begin
        s_dout <= rd_word[4'(cyc - 14)];
      end else if (cyc == 30) begin
        s_dout <= !bad_stop;
      end else begin
        s_oe <= 1'b0;
        sc   <= -1;
      end
    end
  end

  typedef struct {
    logic        rw;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        no_slave;
    logic        bad_stop;
    int          exp_c;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;

  function automatic logic exp_bit(input vec_t v, input int c);
    if (c == 0) return 1'b0;
    if (c == 1) return v.rw;
    if (c <= 9) return v.addr[3'(c - 2)];
    return v.wdata[4'(c - 10)];
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) chk({name, "_ready_timeout"}, 32'(n), 32'd0);
  endtask

  task automatic run_cmd(input vec_t v, input string name);
    int   rsp_c = -1;
    int   last;
    int   wr0;
    logic seq_ok = 1'b1;
    logic gap_ok = 1'b1;
    present      = !v.no_slave;
    bad_stop     = v.bad_stop;
    wr0          = wr_pulses;
    bus.cmd_rw   = v.rw;
    bus.cmd_addr = v.addr;
    bus.cmd_wdata = v.wdata;
    bus.cmd_valid = 1'b1;
    wait_ready(name);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk({name, "_busy_c0"}, 32'(bus.busy), 32'd1);
    last = v.rw ? 25 : 9;
    for (int c = 0; c < 64; c++) begin
      if (c <= last && SDA !== exp_bit(v, c)) seq_ok = 1'b0;
      if (bus.rsp_valid === 1'b1) begin
        rsp_c = c;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_sda_seq"}, 32'(seq_ok), 32'd1);
    chk({name, "_rsp_cycle"}, 32'(rsp_c), 32'(v.exp_c));
    chk({name, "_rdata"}, 32'(bus.rsp_rdata), 32'(v.exp_rd));
    chk({name, "_err"}, 32'(bus.rsp_err), 32'(v.exp_err));
    chk({name, "_sda_rsp"}, 32'(SDA), 32'd1);
    for (int g = 1; g < int'(GAP); g++) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0 || SDA !== 1'b1) gap_ok = 1'b0;
    end
    @(negedge clk);
    chk({name, "_gap"}, 32'(gap_ok), 32'd1);
    chk({name, "_idle_ready"}, {bus.cmd_ready, bus.rsp_valid}, 32'b10);
    if (v.rw) begin
      chk({name, "_wr_pulses"}, 32'(wr_pulses - wr0), 32'd1);
      chk({name, "_mem"}, 32'(mem[v.addr]), 32'(v.wdata));
    end
    present  = 1'b1;
    bad_stop = 1'b0;
  endtask

  vec_t vecs [9];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   c1;
    int   k;
    int   wr0;
    logic rsp_seen;

    //            rw   addr   wdata    nosl  bstop exp_c       exp_rd    err
    vecs[0] = '{1'b1, 8'h3C, 16'hA55A, 1'b0, 1'b0, 26,         16'h0000, 1'b0};
    vecs[1] = '{1'b0, 8'h3C, 16'h0000, 1'b0, 1'b0, 32,         16'hA55A, 1'b0};
    vecs[2] = '{1'b0, 8'h10, 16'h0000, 1'b1, 1'b0, 10 + TO,    16'h0000, 1'b1};
    vecs[3] = '{1'b0, 8'h3C, 16'h0000, 1'b0, 1'b1, 32,         16'hA55A, 1'b1};
    vecs[4] = '{1'b1, 8'hFF, 16'hFFFF, 1'b0, 1'b0, 26,         16'h0000, 1'b0};
    vecs[5] = '{1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0, 32,         16'hFFFF, 1'b0};
    vecs[6] = '{1'b1, 8'h00, 16'h8001, 1'b0, 1'b0, 26,         16'h0000, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 32,         16'h8001, 1'b0};
    vecs[8] = '{1'b0, 8'hFF, 16'h0000, 1'b0, 1'b0, 32,         16'hFFFF, 1'b0};

    bus.cmd_valid = 1'b0;
    bus.cmd_rw    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_sda", 32'(SDA), 32'd1);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back: valid held across write then read; fields changed while busy.
    bus.cmd_rw    = 1'b1;
    bus.cmd_addr  = 8'h01;
    bus.cmd_wdata = 16'h1234;
    bus.cmd_valid = 1'b1;
    wait_ready("b2b");
    @(negedge clk);
    bus.cmd_rw    = 1'b0;
    bus.cmd_wdata = 16'hFFFF;
    c1 = -1;
    for (int c = 0; c < 64; c++) begin
      if (bus.rsp_valid === 1'b1) begin
        c1 = c;
        break;
      end
      @(negedge clk);
    end
    chk("b2b_wr_rsp_cycle", 32'(c1), 32'd26);
    chk("b2b_wr_err", 32'(bus.rsp_err), 32'd0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (SDA !== 1'b0 && k < 20);
    chk("b2b_start_spacing", 32'(k), 32'(GAP + 1));
    bus.cmd_valid = 1'b0;
    c1 = -1;
    for (int c = 0; c < 64; c++) begin
      if (bus.rsp_valid === 1'b1) begin
        c1 = c;
        break;
      end
      @(negedge clk);
    end
    chk("b2b_rd_rsp_cycle", 32'(c1), 32'd32);
    chk("b2b_rd_rdata", 32'(bus.rsp_rdata), 32'h1234);
    chk("b2b_rd_err", 32'(bus.rsp_err), 32'd0);
    @(negedge clk);
    wait_ready("b2b_end");

    // Reset in the middle of a write data phase.
    wr0 = wr_pulses;
    bus.cmd_rw    = 1'b1;
    bus.cmd_addr  = 8'h55;
    bus.cmd_wdata = 16'h0F0F;
    bus.cmd_valid = 1'b1;
    wait_ready("rstmid");
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (15) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstmid_sda", 32'(SDA), 32'd1);
    chk("rstmid_busy", 32'(bus.busy), 32'd0);
    chk("rstmid_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rstmid_rdata", 32'(bus.rsp_rdata), 32'd0);
    rsp_seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) rsp_seen = 1'b1;
    end
    rst = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0 || SDA !== 1'b1) rsp_seen = 1'b1;
    end
    chk("rstmid_no_rsp", 32'(rsp_seen), 32'd0);
    chk("rstmid_no_wr", 32'(wr_pulses - wr0), 32'd0);

    run_cmd('{1'b1, 8'h55, 16'h0F0F, 1'b0, 1'b0, 26, 16'h0000, 1'b0}, "post_rst_wr");
    run_cmd('{1'b0, 8'h55, 16'h0000, 1'b0, 1'b0, 32, 16'h0F0F, 1'b0}, "post_rst_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
